// File: rtl/matrix_mac_engine.sv
// Sequential matrix multiplier C = A x B: one MAC per cycle over k, one write per element.
// Optional MATMUL_SAT_EN: saturate c_data to all ones instead of wrapping the accumulator.
module matrix_mac_engine #(
  parameter int DATA_W  = 32,
  parameter int DIM_MAX = 15,
  parameter int IDX_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  dim_m,
  input  logic [IDX_W-1:0]  dim_k,
  input  logic [IDX_W-1:0]  dim_p,
  output logic [IDX_W-1:0]  a_row,
  output logic [IDX_W-1:0]  a_col,
  output logic [IDX_W-1:0]  b_row,
  output logic [IDX_W-1:0]  b_col,
  output logic              a_rd,
  output logic              b_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [IDX_W-1:0]  c_row,
  output logic [IDX_W-1:0]  c_col,
  output logic [DATA_W-1:0] c_data,
  output logic              c_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int ACC_W = 2*DATA_W + IDX_W;
  localparam logic [IDX_W-1:0] DIM_LIM = IDX_W'(DIM_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, WRITE, FIN} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   m_q, k_q, p_q;
  logic [IDX_W-1:0]   i_q, j_q, k_idx;
  logic [ACC_W-1:0]   acc;
  logic               rd_d, first_d, rej_q;
  logic               done_q, err_q;
  logic [2*DATA_W-1:0] prod;
  logic               dims_bad, k_last, elem_last;

  assign prod      = (2*DATA_W)'(a_data) * (2*DATA_W)'(b_data);
  assign dims_bad  = (m_q == '0) || (k_q == '0) || (p_q == '0) ||
                     (m_q > DIM_LIM) || (k_q > DIM_LIM) || (p_q > DIM_LIM);
  assign k_last    = (k_idx == k_q - 1'b1);
  assign elem_last = (i_q == m_q - 1'b1) && (j_q == p_q - 1'b1);

  // NOTE: async active-low reset with non-blocking assignments; every
  // flop, state included, is cleared the instant reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx = state;
    if (state != IDLE && abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !abort) state_nx = LOAD;
        LOAD:    state_nx = dims_bad ? FIN : MAC;
        MAC:     if (k_last) state_nx = DRAIN;
        DRAIN:   state_nx = WRITE;
        WRITE:   state_nx = elem_last ? FIN : MAC;
        FIN:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    a_rd = (state == MAC);
    b_rd = (state == MAC);
    c_we = (state == WRITE);
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q     <= '0;
      k_q     <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_idx   <= '0;
      acc     <= '0;
      rd_d    <= 1'b0;
      first_d <= 1'b0;
      rej_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Operand data lands one cycle after its strobe, so the MAC lags the issue by one.
      rd_d    <= (state == MAC) && !abort;
      first_d <= (state == MAC) && !abort && (k_idx == '0);
      done_q  <= (state == FIN) && !abort;
      err_q   <= (state == FIN) && !abort && rej_q;

      if (rd_d) acc <= first_d ? ACC_W'(prod) : acc + ACC_W'(prod);

      case (state)
        IDLE: if (start && !abort) begin
          m_q <= dim_m;
          k_q <= dim_k;
          p_q <= dim_p;
        end
        LOAD: begin
          i_q   <= '0;
          j_q   <= '0;
          k_idx <= '0;
          rej_q <= dims_bad;
        end
        MAC:  k_idx <= k_last ? '0 : k_idx + 1'b1;
        WRITE: begin
          if (j_q == p_q - 1'b1) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_row = i_q;
  assign a_col = k_idx;
  assign b_row = k_idx;
  assign b_col = j_q;
  assign c_row = i_q;
  assign c_col = j_q;
  assign done  = done_q;
  assign err   = err_q;

`ifdef MATMUL_SAT_EN
  always_comb begin
    if (acc > ACC_W'({DATA_W{1'b1}})) c_data = '1;
    else                              c_data = acc[DATA_W-1:0];
  end
`else
  assign c_data = acc[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Self-checking bench for matrix_mac_engine: directed and random jobs against a
// plain-arithmetic matrix product model, plus reject, abort and reset scenarios.
module tb_matrix_mac_engine;

  localparam int DATA_W  = 8;
  localparam int DIM_MAX = 15;
  localparam int IDX_W   = 5;
  localparam int BOUND   = 5000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [IDX_W-1:0]  dim_m = '0, dim_k = '0, dim_p = '0;
  logic [IDX_W-1:0]  a_row, a_col, b_row, b_col, c_row, c_col;
  logic              a_rd, b_rd, c_we, busy, done, err;
  logic [DATA_W-1:0] a_data = '0, b_data = '0, c_data;

  matrix_mac_engine #(.DATA_W(DATA_W), .DIM_MAX(DIM_MAX), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .dim_m(dim_m), .dim_k(dim_k), .dim_p(dim_p),
    .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .a_rd(a_rd), .b_rd(b_rd), .a_data(a_data), .b_data(b_data),
    .c_row(c_row), .c_col(c_col), .c_data(c_data), .c_we(c_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int c; logic [DATA_W-1:0] d; } wr_t;

  logic [DATA_W-1:0] am [16][16];
  logic [DATA_W-1:0] bm [16][16];
  wr_t wq[$];
  int  nreads, done_cnt;
  int  vectors = 0, errors = 0;

  // Operand memories answer one cycle after the strobe.
  always @(posedge clk) begin
    if (a_rd) a_data <= am[a_row[3:0]][a_col[3:0]];
    if (b_rd) b_data <= bm[b_row[3:0]][b_col[3:0]];
  end

  always @(negedge clk) begin
    if (c_we) wq.push_back('{r: int'(c_row), c: int'(c_col), d: c_data});
    if (a_rd) nreads++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_c(input int i, input int j, input int kk);
    longint s = 0;
    for (int t = 0; t < kk; t++) s += longint'(am[i][t]) * longint'(bm[t][j]);
`ifdef MATMUL_SAT_EN
    if (s > 255) s = 255;
`else
    s = s % 256;
`endif
    return 64'(s);
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        am[i][j] = DATA_W'($urandom);
        bm[i][j] = DATA_W'($urandom);
      end
  endtask

  task automatic clear_logs();
    wq.delete();
    nreads   = 0;
    done_cnt = 0;
  endtask

  // Runs one job end to end; glitch pulses start with junk dims mid-job.
  task automatic run_job(input int m, input int k, input int p, input bit glitch);
    bit rej;
    int cyc, n_exp, n;
    rej   = (m == 0) || (k == 0) || (p == 0) || (m > DIM_MAX) || (k > DIM_MAX) || (p > DIM_MAX);
    n_exp = rej ? 2 : 2 + m*p*(k+2);
    clear_logs();
    @(negedge clk);
    dim_m = IDX_W'(m); dim_k = IDX_W'(k); dim_p = IDX_W'(p);
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    check($sformatf("busy_after_start %0dx%0dx%0d", m, k, p), 64'(busy), 64'd1);
    start = 1'b0;
    dim_m = IDX_W'($urandom); dim_k = IDX_W'($urandom); dim_p = IDX_W'($urandom);
    while (!done && cyc < BOUND) begin
      @(posedge clk); #1;
      cyc++;
      if (glitch) start = (cyc == 9);
    end
    start = 1'b0;
    check($sformatf("done_latency %0dx%0dx%0d", m, k, p), 64'(cyc), 64'(n_exp));
    check($sformatf("err %0dx%0dx%0d", m, k, p), 64'(err), 64'(rej));
    check("busy_at_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("err_one_cycle", 64'(err), 64'd0);
    check("busy_stays_low", 64'(busy), 64'd0);
    check("write_count", 64'(wq.size()), rej ? 64'd0 : 64'(m*p));
    check("read_count", 64'(nreads), rej ? 64'd0 : 64'(m*p*k));
    n = 0;
    if (!rej) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < p; j++) begin
          if (n < wq.size()) begin
            check($sformatf("wr_row[%0d]", n), 64'(wq[n].r), 64'(i));
            check($sformatf("wr_col[%0d]", n), 64'(wq[n].c), 64'(j));
            check($sformatf("wr_data[%0d,%0d]", i, j), 64'(wq[n].d), ref_c(i, j, k));
          end
          n++;
        end
    end
  endtask

  initial begin
    fill_rand();
    #1;
    check("reset_outputs",
          {a_rd, b_rd, c_we, busy, done, err, a_row, a_col, b_row, b_col, c_row, c_col, c_data},
          64'd0);
    @(negedge clk); reset_n = 1'b1;

    // Textbook 2x2x2 product.
    am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
    bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
    run_job(2, 2, 2, 1'b0);
    if (wq.size() == 4) begin
      check("c00", 64'(wq[0].d), 64'd19);
      check("c01", 64'(wq[1].d), 64'd22);
      check("c10", 64'(wq[2].d), 64'd43);
      check("c11", 64'(wq[3].d), 64'd50);
    end else check("c2x2_writes", 64'(wq.size()), 64'd4);

    // Rejected dimensions.
    run_job(2, 0, 2, 1'b0);
    run_job(16, 2, 2, 1'b0);
    run_job(3, 3, 0, 1'b0);

    // Saturation versus wrap on a 1x1x2 sum of 255*255 products.
    am[0][0] = 255; am[0][1] = 255; bm[0][0] = 255; bm[1][0] = 255;
    run_job(1, 2, 1, 1'b0);
`ifdef MATMUL_SAT_EN
    if (wq.size() > 0) check("sat_255", 64'(wq[0].d), 64'd255);
`else
    if (wq.size() > 0) check("wrap_2", 64'(wq[0].d), 64'd2);
`endif

    // Identity times B with a stray start mid-job.
    fill_rand();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) am[i][j] = (i == j) ? 8'd1 : 8'd0;
    run_job(3, 3, 3, 1'b1);
    for (int n = 0; n < wq.size() && n < 9; n++)
      check($sformatf("identity[%0d]", n), 64'(wq[n].d), 64'(bm[n/3][n%3]));

    // Random shapes and a full-size job.
    for (int t = 0; t < 6; t++) begin
      fill_rand();
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0);
    end
    fill_rand();
    run_job(15, 15, 15, 1'b0);

    // Abort during the second element's MAC phase.
    fill_rand();
    clear_logs();
    @(negedge clk);
    dim_m = 1; dim_k = 3; dim_p = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy_low", 64'(busy), 64'd0);
    check("abort_rd_low", 64'(a_rd), 64'd0);
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    check("abort_writes", 64'(wq.size()), 64'd1);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    if (wq.size() > 0) check("abort_first_elem", 64'(wq[0].d), ref_c(0, 0, 3));
    run_job(2, 3, 2, 1'b0);

    // Abort and start together in IDLE: start must be dropped.
    @(negedge clk); abort = 1'b1; start = 1'b1; dim_m = 1; dim_k = 1; dim_p = 1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_beats_start", 64'(busy), 64'd0);

    // Reset mid-MAC, then a clean 1x1x1 job.
    fill_rand();
    @(negedge clk); dim_m = 2; dim_k = 3; dim_p = 2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    check("mid_mac_before_reset", 64'(a_rd), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async_outputs",
          {a_rd, b_rd, c_we, busy, done, err, a_row, a_col, b_row, b_col, c_row, c_col, c_data},
          64'd0);
    @(negedge clk); reset_n = 1'b1;
    am[0][0] = 7; bm[0][0] = 6;
    run_job(1, 1, 1, 1'b0);
    if (wq.size() > 0) check("post_reset_42", 64'(wq[0].d), 64'd42);
    else check("post_reset_write", 64'(wq.size()), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
